// File: rtl/cpu64_l1i_pkg.sv
// Shared constants, address-field positions and FSM encoding for the L1I refill engine.
package cpu64_l1i_pkg;

    localparam int unsigned LINE_WORDS = 8;
    localparam int unsigned WAYS       = 8;
    localparam int unsigned SETS       = 64;

    localparam int unsigned ADDR_W   = 64;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned TAG_W    = 52;
    localparam int unsigned INDEX_W  = 6;
    localparam int unsigned OFFSET_W = 6;
    localparam int unsigned WORD_W   = 3;
    localparam int unsigned WAY_W    = 3;

    localparam int unsigned TAG_MSB   = 63;
    localparam int unsigned TAG_LSB   = 12;
    localparam int unsigned INDEX_MSB = 11;
    localparam int unsigned INDEX_LSB = 6;
    localparam int unsigned WORD_MSB  = 5;
    localparam int unsigned WORD_LSB  = 3;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp,
        StDone
    } refill_state_e;

    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:OFFSET_W] line);
        return {line, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/cpu64_l1i_refill_if.sv
// Miss, memory and array-write signals of the refill engine; master is the engine side.
interface cpu64_l1i_refill_if;
    import cpu64_l1i_pkg::*;

    logic                miss_valid_i;
    logic                miss_ready_o;
    logic [ADDR_W-1:0]   miss_addr_i;
    logic                invalidate_all_i;
    logic [WAYS-1:0]     valid_way_i;

    logic                mem_req_valid_o;
    logic                mem_req_ready_i;
    logic [ADDR_W-1:0]   mem_req_addr_o;
    logic                mem_rsp_valid_i;
    logic [DATA_W-1:0]   mem_rsp_data_i;
    logic                mem_rsp_err_i;

    logic [INDEX_W-1:0]  arr_index_o;
    logic [WORD_W-1:0]   arr_word_o;
    logic [WAY_W-1:0]    arr_way_o;
    logic                arr_we_o;
    logic                arr_set_valid_o;
    logic [TAG_W-1:0]    arr_tag_o;
    logic [DATA_W-1:0]   arr_wdata_o;

    logic                refill_done_o;
    logic                refill_err_o;

    modport master (
        input  miss_valid_i, miss_addr_i, invalidate_all_i, valid_way_i,
        input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i, mem_rsp_err_i,
        output miss_ready_o, mem_req_valid_o, mem_req_addr_o,
        output arr_index_o, arr_word_o, arr_way_o, arr_we_o, arr_set_valid_o,
        output arr_tag_o, arr_wdata_o, refill_done_o, refill_err_o
    );

    modport slave (
        output miss_valid_i, miss_addr_i, invalidate_all_i, valid_way_i,
        output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i, mem_rsp_err_i,
        input  miss_ready_o, mem_req_valid_o, mem_req_addr_o,
        input  arr_index_o, arr_word_o, arr_way_o, arr_we_o, arr_set_valid_o,
        input  arr_tag_o, arr_wdata_o, refill_done_o, refill_err_o
    );

endinterface

// File: rtl/cpu64_l1i_victim_sel.sv
// Victim way choice: lowest invalid way, else a round-robin pointer that advances only
// when it was actually used.
module cpu64_l1i_victim_sel #(
    parameter int unsigned WAYS = 8,
    localparam int unsigned WayW = $clog2(WAYS)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [WAYS-1:0] valid_way_i,
    input  logic            accept_i,
    output logic [WayW-1:0] victim_o
);

    logic [WayW-1:0] rr_q, rr_d;
    logic [WayW-1:0] free_way;
    logic            free_found;

    // Descending scan so the lowest free way wins.
    always_comb begin
        free_found = 1'b0;
        free_way   = '0;
        for (int i = int'(WAYS) - 1; i >= 0; i--) begin
            if (!valid_way_i[i]) begin
                free_found = 1'b1;
                free_way   = WayW'(i);
            end
        end
    end

    assign victim_o = free_found ? free_way : rr_q;

    always_comb begin
        rr_d = rr_q;
        if (accept_i && !free_found) begin
            rr_d = (rr_q == WayW'(WAYS - 1)) ? '0 : rr_q + WayW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/cpu64_l1i_refill.sv
// L1 instruction cache line refill engine: accepts one miss, fetches the line from memory
// and streams the beats into the tag/data arrays of the chosen victim way.
module cpu64_l1i_refill #(
    parameter int unsigned LINE_WORDS = cpu64_l1i_pkg::LINE_WORDS,
    parameter int unsigned WAYS       = cpu64_l1i_pkg::WAYS,
    parameter int unsigned SETS       = cpu64_l1i_pkg::SETS
) (
    input  logic               clk_i,
    input  logic               rst_i,
    cpu64_l1i_refill_if.master bus
);
    import cpu64_l1i_pkg::*;

    localparam int unsigned BeatW = $clog2(LINE_WORDS);
    localparam int unsigned WayW  = $clog2(WAYS);
    localparam int unsigned IdxW  = $clog2(SETS);
    localparam logic [BeatW-1:0] LastBeat = BeatW'(LINE_WORDS - 1);

    refill_state_e            state_q, state_d;
    logic [BeatW-1:0]         beat_q, beat_d;
    logic [ADDR_W-1:OFFSET_W] line_q, line_d;
    logic [WayW-1:0]          victim_q, victim_d;
    logic                     err_q, err_d;
    logic                     kill_q, kill_d;

    logic                     accept;
    logic [WayW-1:0]          victim_sel;

    // Byte offset within the line never matters to a line refill.
    logic unused_offset;
    assign unused_offset = ^bus.miss_addr_i[OFFSET_W-1:0];

    cpu64_l1i_victim_sel #(
        .WAYS(WAYS)
    ) u_victim_sel (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .valid_way_i(bus.valid_way_i),
        .accept_i   (accept),
        .victim_o   (victim_sel)
    );

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        line_d   = line_q;
        victim_d = victim_q;
        err_d    = err_q;
        kill_d   = kill_q;
        accept   = 1'b0;

        bus.miss_ready_o    = 1'b0;
        bus.mem_req_valid_o = 1'b0;
        bus.mem_req_addr_o  = line_base(line_q);
        bus.arr_index_o     = INDEX_W'(line_q[INDEX_LSB +: IdxW]);
        bus.arr_word_o      = WORD_W'(beat_q);
        bus.arr_way_o       = WAY_W'(victim_q);
        bus.arr_tag_o       = line_q[TAG_MSB:TAG_LSB];
        bus.arr_wdata_o     = bus.mem_rsp_data_i;
        bus.arr_we_o        = 1'b0;
        bus.arr_set_valid_o = 1'b0;
        bus.refill_done_o   = 1'b0;
        bus.refill_err_o    = 1'b0;

        unique case (state_q)
            StIdle: begin
                bus.miss_ready_o = 1'b1;
                // Index follows the incoming miss so valid_way_i describes the miss set.
                bus.arr_index_o  = INDEX_W'(bus.miss_addr_i[INDEX_LSB +: IdxW]);
                if (bus.miss_valid_i) begin
                    accept   = 1'b1;
                    line_d   = bus.miss_addr_i[ADDR_W-1:OFFSET_W];
                    victim_d = victim_sel;
                    state_d  = StReq;
                end
            end
            StReq: begin
                bus.mem_req_valid_o = 1'b1;
                kill_d = kill_q | bus.invalidate_all_i;
                if (bus.mem_req_ready_i) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                kill_d = kill_q | bus.invalidate_all_i;
                if (bus.mem_rsp_valid_i) begin
                    bus.arr_we_o = 1'b1;
                    err_d  = err_q | bus.mem_rsp_err_i;
                    beat_d = beat_q + BeatW'(1);
                    if (beat_q == LastBeat) begin
                        // A flush or error seen on the final beat still blocks the install.
                        bus.arr_set_valid_o = ~(err_d | kill_d);
                        beat_d  = '0;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                bus.refill_done_o = 1'b1;
                bus.refill_err_o  = err_q | kill_q;
                err_d   = 1'b0;
                kill_d  = 1'b0;
                beat_d  = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            beat_q   <= '0;
            line_q   <= '0;
            victim_q <= '0;
            err_q    <= 1'b0;
            kill_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            line_q   <= line_d;
            victim_q <= victim_d;
            err_q    <= err_d;
            kill_q   <= kill_d;
        end
    end

endmodule

// File: tb/tb_cpu64_l1i_refill.sv
// Directed bench for the L1I refill engine: a table of refill scenarios plus hand-written
// reset-mid-refill sequence.
module tb_cpu64_l1i_refill;
    import cpu64_l1i_pkg::*;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  valid;
        int          err_beat;
        int          inv_beat;
        int          stall;
        bit          inv_idle;
        logic [63:0] exp_req;
        logic [5:0]  exp_idx;
        logic [51:0] exp_tag;
        logic [2:0]  exp_way;
        bit          exp_sv;
        bit          exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cur_vec = -1;
    vec_t vecs[11];
    vec_t post_rst;

    always #5 clk = ~clk;

    cpu64_l1i_refill_if bus ();

    cpu64_l1i_refill #(
        .LINE_WORDS(8),
        .WAYS      (8),
        .SETS      (64)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL vec%0d %s: got %h expected %h", cur_vec, name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.miss_valid_i     = 1'b0;
        bus.invalidate_all_i = 1'b0;
        bus.mem_req_ready_i  = 1'b0;
        bus.mem_rsp_valid_i  = 1'b0;
        bus.mem_rsp_err_i    = 1'b0;
    endtask

    task automatic run_refill(input vec_t v, input int n);
        logic [63:0] d;
        cur_vec = n;
        bus.miss_valid_i     = 1'b1;
        bus.miss_addr_i      = v.addr;
        bus.valid_way_i      = v.valid;
        bus.invalidate_all_i = v.inv_idle;
        #1;
        chk("idle_ready", bus.miss_ready_o, 1);
        chk("idle_index", bus.arr_index_o, v.exp_idx);
        step();
        clear_inputs();
        bus.miss_addr_i = '1;
        bus.valid_way_i = 8'h00;
        for (int s = 0; s < v.stall; s++) begin
            bus.mem_rsp_valid_i = (s == 0);
            #1;
            chk("stall_req_valid", bus.mem_req_valid_o, 1);
            chk("stall_req_addr", bus.mem_req_addr_o, v.exp_req);
            chk("stall_no_we", bus.arr_we_o, 0);
            step();
        end
        bus.mem_rsp_valid_i = 1'b0;
        bus.mem_req_ready_i = 1'b1;
        #1;
        chk("req_valid", bus.mem_req_valid_o, 1);
        chk("req_addr", bus.mem_req_addr_o, v.exp_req);
        chk("req_ready_low", bus.miss_ready_o, 0);
        step();
        bus.mem_req_ready_i = 1'b0;
        for (int b = 0; b < 8; b++) begin
            d = {16'hC0DE, 16'(n), 32'(b)};
            bus.mem_rsp_valid_i  = 1'b1;
            bus.mem_rsp_data_i   = d;
            bus.mem_rsp_err_i    = (b == v.err_beat);
            bus.invalidate_all_i = (b == v.inv_beat);
            #1;
            chk("beat_we", bus.arr_we_o, 1);
            chk("beat_word", bus.arr_word_o, 64'(b));
            chk("beat_way", bus.arr_way_o, v.exp_way);
            chk("beat_index", bus.arr_index_o, v.exp_idx);
            chk("beat_tag", bus.arr_tag_o, v.exp_tag);
            chk("beat_wdata", bus.arr_wdata_o, d);
            chk("beat_set_valid", bus.arr_set_valid_o, (b == 7) ? v.exp_sv : 1'b0);
            chk("beat_no_req", bus.mem_req_valid_o, 0);
            step();
        end
        clear_inputs();
        #1;
        chk("done_pulse", bus.refill_done_o, 1);
        chk("done_err", bus.refill_err_o, v.exp_err);
        chk("done_not_ready", bus.miss_ready_o, 0);
        chk("done_no_we", bus.arr_we_o, 0);
        step();
        chk("after_done", bus.refill_done_o, 0);
        chk("after_ready", bus.miss_ready_o, 1);
    endtask

    initial begin
        //          addr                      valid  err inv stall idle req                       idx    tag                   way   sv    err
        vecs[0]  = '{64'h0000_0000_0001_2340, 8'h00, 8, 8, 0, 1'b0, 64'h0000_0000_0001_2340, 6'h0D, 52'h12,              3'd0, 1'b1, 1'b0};
        vecs[1]  = '{64'hDEAD_BEEF_CAFE_1FC8, 8'hFF, 8, 8, 0, 1'b0, 64'hDEAD_BEEF_CAFE_1FC0, 6'h3F, 52'hD_EADB_EEFC_AFE1,  3'd0, 1'b1, 1'b0};
        vecs[2]  = '{64'h0000_0000_8000_0040, 8'hFF, 8, 8, 0, 1'b0, 64'h0000_0000_8000_0040, 6'h01, 52'h80000,           3'd1, 1'b1, 1'b0};
        vecs[3]  = '{64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 8, 8, 0, 1'b0, 64'hFFFF_FFFF_FFFF_FFC0, 6'h3F, 52'hF_FFFF_FFFF_FFFF,  3'd2, 1'b1, 1'b0};
        vecs[4]  = '{64'h0000_0000_0000_1000, 8'hFF, 8, 8, 0, 1'b0, 64'h0000_0000_0000_1000, 6'h00, 52'h1,               3'd3, 1'b1, 1'b0};
        vecs[5]  = '{64'h0000_0000_0000_2080, 8'hF7, 8, 8, 0, 1'b0, 64'h0000_0000_0000_2080, 6'h02, 52'h2,               3'd3, 1'b1, 1'b0};
        vecs[6]  = '{64'h0000_0000_0000_3000, 8'hFF, 8, 8, 0, 1'b0, 64'h0000_0000_0000_3000, 6'h00, 52'h3,               3'd4, 1'b1, 1'b0};
        vecs[7]  = '{64'h0000_0000_0000_4100, 8'h01, 2, 8, 0, 1'b0, 64'h0000_0000_0000_4100, 6'h04, 52'h4,               3'd1, 1'b0, 1'b1};
        vecs[8]  = '{64'h0000_0000_0000_5140, 8'h03, 8, 4, 0, 1'b0, 64'h0000_0000_0000_5140, 6'h05, 52'h5,               3'd2, 1'b0, 1'b1};
        vecs[9]  = '{64'h0000_0000_0000_6188, 8'h7F, 8, 8, 5, 1'b0, 64'h0000_0000_0000_6180, 6'h06, 52'h6,               3'd7, 1'b1, 1'b0};
        vecs[10] = '{64'h0000_0000_0000_7FC0, 8'hFF, 8, 8, 0, 1'b1, 64'h0000_0000_0000_7FC0, 6'h3F, 52'h7,               3'd5, 1'b1, 1'b0};
        post_rst = '{64'h0000_0000_0000_8040, 8'hFF, 8, 8, 0, 1'b0, 64'h0000_0000_0000_8040, 6'h01, 52'h8,               3'd0, 1'b1, 1'b0};

        rst = 1'b1;
        clear_inputs();
        bus.miss_addr_i    = '0;
        bus.valid_way_i    = '0;
        bus.mem_rsp_data_i = '0;
        step();
        step();
        chk("rst_ready", bus.miss_ready_o, 1);
        chk("rst_req_valid", bus.mem_req_valid_o, 0);
        chk("rst_we", bus.arr_we_o, 0);
        chk("rst_set_valid", bus.arr_set_valid_o, 0);
        chk("rst_done", bus.refill_done_o, 0);
        chk("rst_err", bus.refill_err_o, 0);
        rst = 1'b0;
        step();

        for (int n = 0; n < 11; n++) begin
            run_refill(vecs[n], n);
        end

        // Reset lands after beat 3; the remaining beats must not reach the arrays.
        cur_vec = 100;
        bus.miss_valid_i = 1'b1;
        bus.miss_addr_i  = 64'h0000_0000_0000_9000;
        bus.valid_way_i  = 8'h00;
        step();
        bus.miss_valid_i    = 1'b0;
        bus.mem_req_ready_i = 1'b1;
        step();
        bus.mem_req_ready_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
            bus.mem_rsp_valid_i = 1'b1;
            bus.mem_rsp_data_i  = 64'(b);
            #1;
            chk("pre_rst_we", bus.arr_we_o, 1);
            step();
        end
        bus.mem_rsp_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_ready", bus.miss_ready_o, 1);
        chk("midrst_req_valid", bus.mem_req_valid_o, 0);
        chk("midrst_done", bus.refill_done_o, 0);
        step();
        rst = 1'b0;
        for (int b = 4; b < 8; b++) begin
            bus.mem_rsp_valid_i = 1'b1;
            bus.mem_rsp_data_i  = 64'(b);
            #1;
            chk("post_rst_no_we", bus.arr_we_o, 0);
            chk("post_rst_ready", bus.miss_ready_o, 1);
            chk("post_rst_no_done", bus.refill_done_o, 0);
            step();
        end
        clear_inputs();
        step();
        // Pointer was cleared by reset, so a full set picks way 0 again.
        run_refill(post_rst, 101);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
